// File: rtl/bitstream_src_pkg.sv
// Shared types and sizing helpers for the bitstream_src serialiser.
package bitstream_src_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam int GAP_CW = 4;

  function automatic int bit_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/bitstream_shreg.sv
// Loadable shift register; head_o is the next bit to send, direction fixed by MSB_FIRST.
module bitstream_shreg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] load_dat_i,
  output logic             head_o
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = load_dat_i;
    end else if (shift_i) begin
      sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign head_o = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/bitstream_src.sv
// Word-to-serial source: one holding register feeding a shift register, one bit per clock on x.
// Optional even-parity bit per word when BITSTREAM_SRC_PARITY_EN is defined.
module bitstream_src
  import bitstream_src_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CNT_W = bit_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [GAP_CW-1:0] LAST_GAP = GAP_CW'((GAP > 0) ? GAP - 1 : 0);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    hold_q, hold_d;
  logic                hold_full_q, hold_full_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GAP_CW-1:0]   gap_q, gap_d;
  logic                x_q, x_d;
  logic                x_valid_q, x_valid_d;
  logic                frame_start_q, frame_start_d;
  logic                accept, load_sr, shift_sr, sr_head;
`ifdef BITSTREAM_SRC_PARITY_EN
  logic                parity_q, parity_d;
`endif

  bitstream_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk_i     (clk),
    .clr_n_i   (reset),
    .load_i    (load_sr),
    .shift_i   (shift_sr),
    .load_dat_i(hold_q),
    .head_o    (sr_head)
  );

  assign accept = din_valid & ~hold_full_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    gap_d         = gap_q;
    load_sr       = 1'b0;
    shift_sr      = 1'b0;
    x_d           = 1'b0;
    x_valid_d     = 1'b0;
    frame_start_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          load_sr = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        x_d           = sr_head;
        x_valid_d     = 1'b1;
        frame_start_d = (cnt_q == '0);
        shift_sr      = 1'b1;
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
          gap_d = '0;
`ifdef BITSTREAM_SRC_PARITY_EN
          state_d = ST_PAR;
`else
          // With no gap, chaining the next word here keeps the stream bubble-free.
          if (GAP > 0) begin
            state_d = ST_GAP;
          end else if (hold_full_q) begin
            load_sr = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef BITSTREAM_SRC_PARITY_EN
      ST_PAR: begin
        x_d       = parity_q;
        x_valid_d = 1'b1;
        gap_d     = '0;
        if (GAP > 0) begin
          state_d = ST_GAP;
        end else if (hold_full_q) begin
          load_sr = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif

      ST_GAP: begin
        // The last gap cycle doubles as the load cycle so the gap is exactly GAP long.
        if (gap_q == LAST_GAP) begin
          if (hold_full_q) begin
            load_sr = 1'b1;
            cnt_d   = '0;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    hold_d      = accept ? din : hold_q;
    hold_full_d = (hold_full_q & ~load_sr) | accept;
  end

`ifdef BITSTREAM_SRC_PARITY_EN
  assign parity_d = load_sr ? ^hold_q : parity_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      cnt_q         <= '0;
      gap_q         <= '0;
      x_q           <= 1'b0;
      x_valid_q     <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef BITSTREAM_SRC_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      cnt_q         <= cnt_d;
      gap_q         <= gap_d;
      x_q           <= x_d;
      x_valid_q     <= x_valid_d;
      frame_start_q <= frame_start_d;
`ifdef BITSTREAM_SRC_PARITY_EN
      parity_q      <= parity_d;
`endif
    end
  end

  assign din_ready   = ~hold_full_q;
  assign busy        = (state_q != ST_IDLE) | hold_full_q;
  assign x           = x_q;
  assign x_valid     = x_valid_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bitstream_src.sv
// Bench for bitstream_src: an MSB-first gapless instance and an LSB-first GAP=2 instance.
module tb_bitstream_src;

  localparam int W = 8;
`ifdef BITSTREAM_SRC_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int P = W + PB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [W-1:0] d_din;
  logic         d_vld, sel, vld_all;
  logic a_vld, a_rdy, a_x, a_xv, a_fs, a_busy;
  logic b_vld, b_rdy, b_x, b_xv, b_fs, b_busy;
  logic c_rdy, c_x, c_xv, c_fs, c_busy;

  int n_cmp = 0;
  int n_bad = 0;

  assign a_vld  = vld_all | (d_vld & ~sel);
  assign b_vld  = vld_all | (d_vld & sel);
  assign c_rdy  = sel ? b_rdy  : a_rdy;
  assign c_x    = sel ? b_x    : a_x;
  assign c_xv   = sel ? b_xv   : a_xv;
  assign c_fs   = sel ? b_fs   : a_fs;
  assign c_busy = sel ? b_busy : a_busy;

  bitstream_src #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP(0)) u_a (
    .clk(clk), .reset(reset), .din(d_din), .din_valid(a_vld), .din_ready(a_rdy),
    .x(a_x), .x_valid(a_xv), .frame_start(a_fs), .busy(a_busy)
  );

  bitstream_src #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP(2)) u_b (
    .clk(clk), .reset(reset), .din(d_din), .din_valid(b_vld), .din_ready(b_rdy),
    .x(b_x), .x_valid(b_xv), .frame_start(b_fs), .busy(b_busy)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serial order of a frame: data bits in configured order, then the even-parity bit.
  function automatic logic exp_bit(input logic [W-1:0] w, input int i, input logic msb);
    if (i >= W) return ^w;
    return msb ? w[W-1-i] : w[i];
  endfunction

  function automatic int gap_of(input logic s);
    return s ? 2 : 0;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (c_busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    n_cmp++;
    if (c_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", c_busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; vld_all = 1'b1; d_vld = 1'b0; sel = 1'b0;
    d_din = W'($urandom);
    repeat (3) begin
      tick();
      n_cmp++;
      if ({a_x, a_xv, a_fs, a_busy, a_rdy, b_x, b_xv, b_fs, b_busy, b_rdy} !== 10'b00001_00001) begin
        n_bad++;
        $display("FAIL reset_hold: got a=%b%b%b%b%b b=%b%b%b%b%b want 00001 00001",
                 a_x, a_xv, a_fs, a_busy, a_rdy, b_x, b_xv, b_fs, b_busy, b_rdy);
      end
    end
    vld_all = 1'b0; reset = 1'b1;
    repeat (2) begin
      tick();
      n_cmp++;
      if ({a_xv, a_busy, a_rdy, b_xv, b_busy, b_rdy} !== 6'b001_001) begin
        n_bad++;
        $display("FAIL reset_release: got a=%b%b%b b=%b%b%b want 001 001",
                 a_xv, a_busy, a_rdy, b_xv, b_busy, b_rdy);
      end
    end
  endtask

  task automatic test_single(input logic s, input logic [W-1:0] w);
    int last;
    logic ev, ex, ef;
    sel = s;
    wait_idle();
    d_din = w; d_vld = 1'b1;
    n_cmp++;
    if (c_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_ready_idle: din_ready=%b want 1", c_rdy);
    end
    tick();
    d_vld = 1'b0; d_din = W'($urandom);
    n_cmp++;
    if (c_rdy !== 1'b0 || c_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_after_accept: ready=%b busy=%b want 0 1", c_rdy, c_busy);
    end
    last = P + gap_of(s) + 2;
    for (int k = 1; k <= last; k++) begin
      tick();
      ev = (k >= 2) && (k <= P + 1);
      ex = ev ? exp_bit(w, k - 2, ~s) : 1'b0;
      ef = (k == 2);
      n_cmp++;
      if ({c_xv, c_x, c_fs} !== {ev, ex, ef}) begin
        n_bad++;
        $display("FAIL single_bit sel=%0d word=%h k=%0d: got v/x/fs=%b%b%b want %b%b%b",
                 s, w, k, c_xv, c_x, c_fs, ev, ex, ef);
      end
    end
    n_cmp++;
    if (c_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_idle_after sel=%0d: busy=%b want 0", s, c_busy);
    end
  endtask

  task automatic test_stream(input logic s, input int n, input logic [W-1:0] w0, input logic [W-1:0] w1);
    logic [W-1:0] words[$];
    int nxt = 0, acc0 = -1, budget, per, nvalid = 0;
    logic ov[], ox[], of[];
    logic ev, ex, ef;
    logic acc;
    sel = s;
    wait_idle();
    words.push_back(w0);
    words.push_back(w1);
    for (int i = 2; i < n; i++) words.push_back(W'($urandom));
    per = P + gap_of(s);
    budget = 2 + n * per + 6;
    ov = new[budget]; ox = new[budget]; of = new[budget];
    d_din = words[0]; d_vld = 1'b1;
    for (int c = 0; c < budget; c++) begin
      acc = d_vld & c_rdy;
      tick();
      if (acc) begin
        if (nxt == 0) acc0 = c;
        nxt++;
        if (nxt < n) d_din = words[nxt];
        else d_vld = 1'b0;
      end
      ov[c] = c_xv; ox[c] = c_x; of[c] = c_fs;
      if (c_xv === 1'b1) nvalid++;
    end
    d_vld = 1'b0;
    n_cmp++;
    if (nxt !== n || acc0 !== 0) begin
      n_bad++;
      $display("FAIL stream_accepts sel=%0d: accepted %0d first@%0d want %0d first@0", s, nxt, acc0, n);
    end
    n_cmp++;
    if (nvalid !== n * P) begin
      n_bad++;
      $display("FAIL stream_valid_count sel=%0d: got %0d want %0d", s, nvalid, n * P);
    end
    // Frame k starts exactly k word-periods after the first bit, which lands two edges after accept.
    for (int c = 0; c < budget; c++) begin
      int rel, k, i;
      rel = c - 2;
      k = (rel >= 0) ? rel / per : -1;
      i = (rel >= 0) ? rel % per : -1;
      ev = (k >= 0) && (k < n) && (i < P);
      ex = ev ? exp_bit(words[k], i, ~s) : 1'b0;
      ef = ev && (i == 0);
      n_cmp++;
      if ({ov[c], ox[c], of[c]} !== {ev, ex, ef}) begin
        n_bad++;
        $display("FAIL stream_bit sel=%0d cycle=%0d: got v/x/fs=%b%b%b want %b%b%b",
                 s, c, ov[c], ox[c], of[c], ev, ex, ef);
      end
    end
  endtask

  task automatic test_random_singles();
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      test_single(1'($urandom_range(0, 1)), W'($urandom));
    end
  endtask

  task automatic test_mid_reset();
    sel = 1'b0;
    wait_idle();
    d_din = 8'hFF; d_vld = 1'b1;
    tick();
    d_vld = 1'b0;
    repeat (5) tick();
    n_cmp++;
    if ({a_xv, a_x, a_fs} !== 3'b110) begin
      n_bad++;
      $display("FAIL midreset_4th_bit: got v/x/fs=%b%b%b want 110", a_xv, a_x, a_fs);
    end
    reset = 1'b0; d_din = W'($urandom); d_vld = 1'b1;
    tick();
    n_cmp++;
    if ({a_xv, a_x, a_fs, a_rdy, a_busy} !== 5'b00010) begin
      n_bad++;
      $display("FAIL midreset_clear: got v/x/fs/rdy/busy=%b%b%b%b%b want 00010",
               a_xv, a_x, a_fs, a_rdy, a_busy);
    end
    reset = 1'b1; d_vld = 1'b0;
    tick();
    n_cmp++;
    if ({a_xv, a_busy, a_rdy} !== 3'b001) begin
      n_bad++;
      $display("FAIL midreset_release: got v/busy/rdy=%b%b%b want 001", a_xv, a_busy, a_rdy);
    end
    test_single(1'b0, 8'h80);
  endtask

`ifdef BITSTREAM_SRC_PARITY_EN
  task automatic test_parity();
    test_single(1'b0, 8'h07);
    test_single(1'b0, 8'hA5);
    test_single(1'b1, W'($urandom));
  endtask
`endif

  initial begin
    reset = 1'b0; d_din = '0; d_vld = 1'b0; sel = 1'b0; vld_all = 1'b0;
    test_reset();
    test_single(1'b0, 8'hA5);
    test_stream(1'b0, 6, 8'hA5, 8'h3C);
    test_stream(1'b1, 4, 8'h01, 8'h01);
    test_random_singles();
    test_stream(1'b0, 5, W'($urandom), W'($urandom));
    test_stream(1'b1, 5, W'($urandom), W'($urandom));
    test_mid_reset();
`ifdef BITSTREAM_SRC_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
